// File: rtl/mem_pkg.sv
// Shared types and constants for the dmem request interface, used by the
// responder, the MEM stage and the stall unit.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_MASK_W = 4;
   localparam int DMEM_CNT_W  = 4;
   localparam int DMEM_ADDR_W = 32;

   // Word index relative to the region base; wraps (unsigned) below base.
   function automatic logic [DMEM_ADDR_W-1:0] dmem_word_index(
      input logic [DMEM_ADDR_W-1:0] addr,
      input logic [DMEM_ADDR_W-1:0] base
   );
      return (addr - base) >> 32'd2;
   endfunction

   // An address below base must fault even though its wrapped index is huge.
   function automatic logic dmem_range_fault(
      input logic [DMEM_ADDR_W-1:0] addr,
      input logic [DMEM_ADDR_W-1:0] base,
      input logic [DMEM_ADDR_W-1:0] depth
   );
      return (addr < base) | (dmem_word_index(addr, base) >= depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with per-byte-lane write enables and a
// registered read port whose output holds until the next read or clear.
module dmem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DMEM_MASK_W-1:0] wr_be,
   input  logic [DMEM_DATA_W-1:0] wr_data,
   input  logic                   rd_en,
   input  logic                   rd_clr,
   input  logic [IDX_W-1:0]       idx,
   output logic [DMEM_DATA_W-1:0] rd_data
);

   logic [DMEM_DATA_W-1:0] mem_r [DEPTH_WORDS];
   logic [DMEM_DATA_W-1:0] rd_data_r;

   // Byte-lane writes; storage is deliberately not reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DMEM_MASK_W; i++) begin
         if (wr_en && wr_be[i]) begin
            mem_r[idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Read register: cleared on reset or a faulted request, else loaded on read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_r <= {DMEM_DATA_W{1'b0}};
      end else if (rd_clr) begin
         rd_data_r <= {DMEM_DATA_W{1'b0}};
      end else if (rd_en) begin
         rd_data_r <= mem_r[idx];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: accepts a load/store from IDLE, waits
// WAIT_CYCLES, commits or faults, then pulses rsp_valid for one cycle.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_rd_en,
   input  logic                   req_wr_en,
   input  logic [DMEM_MASK_W-1:0] req_mask,
   input  logic [DMEM_ADDR_W-1:0] req_addr,
   input  logic [DMEM_DATA_W-1:0] req_wr_data,
   output logic [DMEM_DATA_W-1:0] rd_data,
   output logic                   rsp_valid,
   output logic                   busy,
   output logic                   err
);

   localparam int                     IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [DMEM_CNT_W-1:0]  WAIT_LOAD = DMEM_CNT_W'(WAIT_CYCLES);
   localparam logic [DMEM_ADDR_W-1:0] DEPTH_W32 = DMEM_ADDR_W'(DEPTH_WORDS);

   dmem_state_e            state_r;
   dmem_state_e            state_nxt_s;
   logic [DMEM_CNT_W-1:0]  cnt_r;
   logic [DMEM_CNT_W-1:0]  cnt_nxt_s;

   logic                   req_s;
   logic                   fault_s;
   logic [IDX_W-1:0]       idx_s;
   logic                   capture_s;
   logic                   commit_s;

   logic                   op_wr_r;
   logic                   fault_r;
   logic [IDX_W-1:0]       idx_r;
   logic [DMEM_MASK_W-1:0] mask_r;
   logic [DMEM_DATA_W-1:0] wdata_r;

   logic                   cmt_wr_s;
   logic                   cmt_fault_s;
   logic [IDX_W-1:0]       cmt_idx_s;
   logic [DMEM_MASK_W-1:0] cmt_mask_s;
   logic [DMEM_DATA_W-1:0] cmt_wdata_s;

   logic                   arr_wr_s;
   logic                   arr_rd_s;
   logic                   arr_clr_s;
   logic                   rsp_valid_r;
   logic                   err_r;

   assign req_s   = req_rd_en | req_wr_en;
   assign idx_s   = IDX_W'(dmem_word_index(req_addr, BASE_ADDR));
   assign fault_s = (req_rd_en & req_wr_en)
                  | dmem_range_fault(req_addr, BASE_ADDR, DEPTH_W32);

   // Next-state, counter and accept/commit strobes.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      capture_s   = 1'b0;
      commit_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_s) begin
               capture_s = 1'b1;
               if (WAIT_LOAD == {DMEM_CNT_W{1'b0}}) begin
                  commit_s    = 1'b1;
                  state_nxt_s = RESP;
               end else begin
                  cnt_nxt_s   = WAIT_LOAD;
                  state_nxt_s = WAIT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r != {DMEM_CNT_W{1'b0}}) begin
               cnt_nxt_s = cnt_r - {{(DMEM_CNT_W-1){1'b0}}, 1'b1};
            end else begin
               commit_s    = 1'b1;
               state_nxt_s = RESP;
            end
         end
         RESP: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {DMEM_CNT_W{1'b0}};
         end
      endcase
   end

   // A zero-wait commit happens on the accept edge, so it uses the live request.
   always_comb begin
      if (state_r == IDLE) begin
         cmt_wr_s    = req_wr_en;
         cmt_fault_s = fault_s;
         cmt_idx_s   = idx_s;
         cmt_mask_s  = req_mask;
         cmt_wdata_s = req_wr_data;
      end else begin
         cmt_wr_s    = op_wr_r;
         cmt_fault_s = fault_r;
         cmt_idx_s   = idx_r;
         cmt_mask_s  = mask_r;
         cmt_wdata_s = wdata_r;
      end
   end

   // FSM state, wait counter and response pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= {DMEM_CNT_W{1'b0}};
         rsp_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         rsp_valid_r <= commit_s;
         err_r       <= commit_s & cmt_fault_s;
      end
   end

   // Frozen copy of the accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_wr_r <= 1'b0;
         fault_r <= 1'b0;
         idx_r   <= {IDX_W{1'b0}};
         mask_r  <= {DMEM_MASK_W{1'b0}};
         wdata_r <= {DMEM_DATA_W{1'b0}};
      end else if (capture_s) begin
         op_wr_r <= req_wr_en;
         fault_r <= fault_s;
         idx_r   <= idx_s;
         mask_r  <= req_mask;
         wdata_r <= req_wr_data;
      end
   end

   // Reset on the commit edge aborts the store.
   assign arr_wr_s  = commit_s & cmt_wr_s & ~cmt_fault_s & ~rst;
   assign arr_rd_s  = commit_s & ~cmt_wr_s & ~cmt_fault_s;
   assign arr_clr_s = commit_s & cmt_fault_s;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (arr_wr_s),
      .wr_be   (cmt_mask_s),
      .wr_data (cmt_wdata_s),
      .rd_en   (arr_rd_s),
      .rd_clr  (arr_clr_s),
      .idx     (cmt_idx_s),
      .rd_data (rd_data)
   );

   assign busy      = ((state_r == IDLE) & req_s) | (state_r == WAIT);
   assign rsp_valid = rsp_valid_r;
   assign err       = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (WAIT_CYCLES=2 / depth 1024 and
// WAIT_CYCLES=0 / depth 16), directed table, hand sequences, random ops.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rd_en0, wr_en0, rd_en1, wr_en1;
   logic [3:0]  mask0, mask1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [31:0] rd_data0, rd_data1;
   logic        rsp_valid0, rsp_valid1, busy0, busy1, err0, err1;

   dmem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut0 (
      .clk(clk), .rst(rst), .req_rd_en(rd_en0), .req_wr_en(wr_en0),
      .req_mask(mask0), .req_addr(addr0), .req_wr_data(wdata0),
      .rd_data(rd_data0), .rsp_valid(rsp_valid0), .busy(busy0), .err(err0));

   dmem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(16), .BASE_ADDR(32'h0)) dut1 (
      .clk(clk), .rst(rst), .req_rd_en(rd_en1), .req_wr_en(wr_en1),
      .req_mask(mask1), .req_addr(addr1), .req_wr_data(wdata1),
      .rd_data(rd_data1), .rsp_valid(rsp_valid1), .busy(busy1), .err(err1));

   int total = 0;
   int bad   = 0;

   // Reference model: sparse word store per DUT plus expected read register.
   bit [31:0]   mem0 [bit [31:0]];
   bit [31:0]   mem1 [bit [31:0]];
   logic [31:0] rd_exp   [2];
   bit          rd_known [2];

   typedef struct {
      int          d;
      logic        rd;
      logic        wr;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[$];

   function automatic logic       g_rsp(input int d);  return (d == 0) ? rsp_valid0 : rsp_valid1; endfunction
   function automatic logic       g_busy(input int d); return (d == 0) ? busy0 : busy1;           endfunction
   function automatic logic       g_err(input int d);  return (d == 0) ? err0 : err1;             endfunction
   function automatic logic [31:0] g_rd(input int d);  return (d == 0) ? rd_data0 : rd_data1;     endfunction
   function automatic int wait_cycles(input int d);    return (d == 0) ? 2 : 0;                   endfunction
   function automatic int depth_of(input int d);       return (d == 0) ? 1024 : 16;               endfunction
   // accept edge, WAIT_CYCLES+1 wait cycles, then RESP; zero-wait skips WAIT
   function automatic int exp_lat(input int d);
      return (wait_cycles(d) == 0) ? 1 : wait_cycles(d) + 2;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input int d, input logic rd, input logic wr, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] wd);
      if (d == 0) begin
         rd_en0 = rd; wr_en0 = wr; mask0 = m; addr0 = a; wdata0 = wd;
      end else begin
         rd_en1 = rd; wr_en1 = wr; mask1 = m; addr1 = a; wdata1 = wd;
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         rd_exp[d]   = 32'h0;
         rd_known[d] = 1'b1;
      end
   endtask

   task automatic model_apply(input int d, input logic rd, input logic wr, input logic [3:0] m,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic exp_err, output logic [31:0] exp_rd, output logic chk_rd);
      bit [31:0] w;
      bit [31:0] wi;
      bit        known;
      wi      = a / 4;
      exp_err = (rd && wr) || (wi >= depth_of(d));
      if (exp_err) begin
         rd_exp[d]   = 32'h0;
         rd_known[d] = 1'b1;
      end else begin
         known = (d == 0) ? mem0.exists(wi) : mem1.exists(wi);
         w     = known ? ((d == 0) ? mem0[wi] : mem1[wi]) : 32'h0;
         if (wr) begin
            for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = wd[8*i +: 8];
            if (d == 0) mem0[wi] = w; else mem1[wi] = w;
         end else begin
            rd_exp[d]   = w;
            rd_known[d] = known;
         end
      end
      exp_rd = rd_exp[d];
      chk_rd = rd_known[d];
   endtask

   // Issue one request from a negedge and check busy, latency, pulse and result.
   task automatic run_req(input string nm, input int d, input logic rd, input logic wr,
                          input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd, input logic chk_rd,
                          input bit scramble);
      int lat;
      bit busy_ok;
      lat     = 0;
      busy_ok = 1'b1;
      drive(d, rd, wr, m, a, wd);
      #1;
      check({nm, "/busy_req"}, g_busy(d), 32'd1);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (g_rsp(d)) begin
            lat = c;
            break;
         end
         if (!g_busy(d)) busy_ok = 1'b0;
         if (scramble) drive(d, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom);
      end
      check({nm, "/latency"}, lat, exp_lat(d));
      check({nm, "/busy_wait"}, busy_ok, 32'd1);
      check({nm, "/busy_resp"}, g_busy(d), 32'd0);
      check({nm, "/err"}, g_err(d), exp_err);
      if (chk_rd) check({nm, "/rd_data"}, g_rd(d), exp_rd);
      drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check({nm, "/pulse"}, g_rsp(d), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e_err, e_chk;
      logic [31:0] e_rd, rd_a, rd_b;
      bit          seen;
      int          d, kind;
      logic [31:0] a, wd;
      logic [3:0]  m;

      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset%0d/rd_data", i), g_rd(i), 32'h0);
         check($sformatf("reset%0d/rsp_valid", i), g_rsp(i), 32'd0);
         check($sformatf("reset%0d/err", i), g_err(i), 32'd0);
         check($sformatf("reset%0d/busy", i), g_busy(i), 32'd0);
      end
      rst = 1'b0;
      model_reset();
      @(negedge clk);

      //            d  rd    wr    mask   addr          wdata          err   rd_data
      tbl.push_back('{0, 1'b0, 1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 1'b0, 32'h00000000});
      tbl.push_back('{0, 1'b1, 1'b0, 4'hF, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF});
      tbl.push_back('{0, 1'b0, 1'b1, 4'h2, 32'h10,       32'h0000AA00, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{0, 1'b1, 1'b0, 4'hF, 32'h10,       32'h0,        1'b0, 32'hDEADAAEF});
      tbl.push_back('{0, 1'b0, 1'b1, 4'hF, 32'h20,       32'h11223344, 1'b0, 32'hDEADAAEF});
      tbl.push_back('{0, 1'b1, 1'b1, 4'hF, 32'h20,       32'hFFFFFFFF, 1'b1, 32'h00000000});
      tbl.push_back('{0, 1'b1, 1'b0, 4'hF, 32'h20,       32'h0,        1'b0, 32'h11223344});
      tbl.push_back('{0, 1'b1, 1'b0, 4'hF, 32'h1000,     32'h0,        1'b1, 32'h00000000});
      tbl.push_back('{0, 1'b1, 1'b0, 4'hF, 32'h10,       32'h0,        1'b0, 32'hDEADAAEF});
      tbl.push_back('{0, 1'b1, 1'b0, 4'hF, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h00000000});
      tbl.push_back('{0, 1'b0, 1'b1, 4'h0, 32'h10,       32'hFFFFFFFF, 1'b0, 32'h00000000});
      tbl.push_back('{0, 1'b1, 1'b0, 4'hF, 32'h10,       32'h0,        1'b0, 32'hDEADAAEF});
      tbl.push_back('{0, 1'b0, 1'b1, 4'hF, 32'h30,       32'hCAFEF00D, 1'b0, 32'hDEADAAEF});
      tbl.push_back('{0, 1'b0, 1'b1, 4'hF, 32'hFFC,      32'h5A5A5A5A, 1'b0, 32'hDEADAAEF});
      tbl.push_back('{0, 1'b1, 1'b0, 4'hF, 32'hFFC,      32'h0,        1'b0, 32'h5A5A5A5A});
      tbl.push_back('{1, 1'b0, 1'b1, 4'hF, 32'h3C,       32'h0A0B0C0D, 1'b0, 32'h00000000});
      tbl.push_back('{1, 1'b1, 1'b0, 4'hF, 32'h3C,       32'h0,        1'b0, 32'h0A0B0C0D});
      tbl.push_back('{1, 1'b1, 1'b0, 4'hF, 32'h40,       32'h0,        1'b1, 32'h00000000});

      foreach (tbl[i]) begin
         model_apply(tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].mask, tbl[i].addr, tbl[i].wdata,
                     e_err, e_rd, e_chk);
         run_req($sformatf("tbl%0d", i), tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].mask,
                 tbl[i].addr, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rd, 1'b1, 1'b0);
      end

      // Reset during WAIT of a store: aborted, no response, word keeps old value.
      drive(0, 1'b0, 1'b1, 4'hF, 32'h30, 32'h12345678);
      @(negedge clk);
      @(negedge clk);
      check("rstwait/busy_before", busy0, 32'd1);
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("rstwait/busy", busy0, 32'd0);
      check("rstwait/rsp_valid", rsp_valid0, 32'd0);
      check("rstwait/err", err0, 32'd0);
      check("rstwait/rd_data", rd_data0, 32'h0);
      rst = 1'b0;
      model_reset();
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid0 || busy0) seen = 1'b1;
      end
      check("rstwait/quiet", seen, 32'd0);
      model_apply(0, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0, e_err, e_rd, e_chk);
      run_req("rstwait/read", 0, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0);

      // Zero-wait back-to-back reads: response every second cycle.
      model_apply(1, 1'b0, 1'b1, 4'hF, 32'h0, 32'h11110000, e_err, e_rd, e_chk);
      run_req("b2b/wr0", 1, 1'b0, 1'b1, 4'hF, 32'h0, 32'h11110000, e_err, e_rd, e_chk, 1'b0);
      model_apply(1, 1'b0, 1'b1, 4'hF, 32'h4, 32'h22220004, e_err, e_rd, e_chk);
      run_req("b2b/wr4", 1, 1'b0, 1'b1, 4'hF, 32'h4, 32'h22220004, e_err, e_rd, e_chk, 1'b0);
      model_apply(1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, e_err, rd_a, e_chk);
      model_apply(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, e_err, rd_b, e_chk);
      drive(1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
      @(negedge clk);
      check("b2b/c1_rsp", rsp_valid1, 32'd1);
      check("b2b/c1_rd", rd_data1, rd_a);
      drive(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
      #1;
      check("b2b/c1_busy", busy1, 32'd0);
      @(negedge clk);
      check("b2b/c2_rsp", rsp_valid1, 32'd0);
      check("b2b/c2_busy", busy1, 32'd1);
      @(negedge clk);
      check("b2b/c3_rsp", rsp_valid1, 32'd1);
      check("b2b/c3_rd", rd_data1, rd_b);
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("b2b/c4_rsp", rsp_valid1, 32'd0);

      // Prefill an 8-word window on each DUT so random partial writes are defined.
      for (int dd = 0; dd < 2; dd++) begin
         for (int w = 0; w < 8; w++) begin
            a  = ((dd == 0) ? 32'h40 : 32'h20) + 32'(4 * w);
            wd = $urandom;
            model_apply(dd, 1'b0, 1'b1, 4'hF, a, wd, e_err, e_rd, e_chk);
            run_req($sformatf("fill%0d_%0d", dd, w), dd, 1'b0, 1'b1, 4'hF, a, wd,
                    e_err, e_rd, e_chk, 1'b0);
         end
      end

      for (int n = 0; n < 60; n++) begin
         d    = int'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 9));
         m    = 4'($urandom);
         wd   = $urandom;
         a    = ((d == 0) ? 32'h40 : 32'h20) + 32'(4 * $urandom_range(0, 7));
         if (kind >= 8) begin
            if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFC - 32'(4 * $urandom_range(0, 3));
            else if (d == 0) a = 32'h1000 + 32'(4 * $urandom_range(16, 23));
            else a = 32'h40 + 32'(4 * $urandom_range(0, 31));
         end
         case (kind)
            0, 1, 2, 3, 8: begin
               model_apply(d, 1'b1, 1'b0, m, a, wd, e_err, e_rd, e_chk);
               run_req($sformatf("rnd%0d_rd", n), d, 1'b1, 1'b0, m, a, wd, e_err, e_rd, e_chk, d == 0);
            end
            4, 5, 6, 9: begin
               model_apply(d, 1'b0, 1'b1, m, a, wd, e_err, e_rd, e_chk);
               run_req($sformatf("rnd%0d_wr", n), d, 1'b0, 1'b1, m, a, wd, e_err, e_rd, e_chk, d == 0);
            end
            default: begin
               model_apply(d, 1'b1, 1'b1, m, a, wd, e_err, e_rd, e_chk);
               run_req($sformatf("rnd%0d_both", n), d, 1'b1, 1'b1, m, a, wd, e_err, e_rd, e_chk, d == 0);
            end
         endcase
      end

      // Read back the whole window so any aliased or dropped store shows up.
      for (int dd = 0; dd < 2; dd++) begin
         for (int w = 0; w < 8; w++) begin
            a = ((dd == 0) ? 32'h40 : 32'h20) + 32'(4 * w);
            model_apply(dd, 1'b1, 1'b0, 4'hF, a, 32'h0, e_err, e_rd, e_chk);
            run_req($sformatf("final%0d_%0d", dd, w), dd, 1'b1, 1'b0, 4'hF, a, 32'h0,
                    e_err, e_rd, e_chk, 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
